// File: rtl/cpu_datapath.sv
// Single-bus 32-bit CPU datapath: register file, PC/IR/Y/Z/MAR/MDR, ALU and word RAM.
module cpu_datapath #(
  parameter int    MEM_DEPTH     = 512,
  parameter string MEM_INIT_FILE = "memory.hex"
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PC_enable,
  input  logic        PC_increment_enable,
  input  logic        IR_enable,
  input  logic        Y_enable,
  input  logic        Z_enable,
  input  logic        MAR_enable,
  input  logic        MDR_enable,
  input  logic        r_enable,
  input  logic        read,
  input  logic        write,
  input  logic        Gra,
  input  logic        Grb,
  input  logic        ba_select,
  input  logic        PC_select,
  input  logic        Z_LO_select,
  input  logic        MDR_select,
  input  logic        c_select,
  input  logic        r_select,
  input  logic [4:0]  alu_instruction,
  output logic [4:0]  bus_select,
  output logic [15:0] register_select,
  output logic [31:0] bus_Data,
  output logic [31:0] R2_Data,
  output logic [31:0] R3_Data,
  output logic [31:0] PC_Data,
  output logic [31:0] IR_Data,
  output logic [31:0] Y_Data,
  output logic [31:0] Z_HI_Data,
  output logic [31:0] Z_LO_Data,
  output logic [31:0] MAR_Data,
  output logic [31:0] MDR_Data,
  output logic [31:0] MDataIN
);

  localparam int ADDR_W = $clog2(MEM_DEPTH);

  logic [31:0] r_q [16];
  logic [31:0] r_d [16];
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] y_q, y_d;
  logic [31:0] z_hi_q, z_hi_d;
  logic [31:0] z_lo_q, z_lo_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;

  logic [31:0] mem [MEM_DEPTH] = '{default: '0};

  logic [3:0]  reg_idx;
  logic [31:0] c_ext;
  logic [31:0] bus_value;
  logic [4:0]  bus_code;
  logic [31:0] mem_rdata;
  logic [31:0] mdata_in;
  logic [ADDR_W-1:0] mem_addr;

  // IR fields: Ra, Rb and the 19-bit signed constant
  assign reg_idx = (Gra ? ir_q[26:23] : 4'd0) | (Grb ? ir_q[22:19] : 4'd0);
  assign c_ext   = {{13{ir_q[18]}}, ir_q[18:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_regs
      assign register_select[gi] = (Gra || Grb) && (reg_idx == 4'(gi));
      assign r_d[gi] = (r_enable && register_select[gi]) ? bus_value : r_q[gi];
    end
  endgenerate

  // Bus source priority encoder
  always_comb begin
    bus_value = '0;
    bus_code  = 5'd31;
    if (r_select || ba_select) begin
      bus_code  = {1'b0, reg_idx};
      bus_value = (ba_select && reg_idx == 4'd0) ? 32'd0 : r_q[reg_idx];
    end else if (Z_LO_select) begin
      bus_code  = 5'd17;
      bus_value = z_lo_q;
    end else if (PC_select) begin
      bus_code  = 5'd18;
      bus_value = pc_q;
    end else if (MDR_select) begin
      bus_code  = 5'd19;
      bus_value = mdr_q;
    end else if (c_select) begin
      bus_code  = 5'd20;
      bus_value = c_ext;
    end
  end

  // Asynchronous read so a MAR loaded in one cycle can be read into MDR the next
  assign mem_addr  = mar_q[ADDR_W-1:0];
  assign mem_rdata = mem[mem_addr];
  assign mdata_in  = read ? mem_rdata : bus_value;

  always_ff @(posedge clk) begin
    if (write) begin
      mem[mem_addr] <= mdr_q;
    end
  end

  logic signed [63:0] y_ext, b_ext, prod, quo, rem;
  logic [63:0] rot_r, rot_l;
  logic [4:0]  amt;
  logic [31:0] alu_hi, alu_lo;

  assign y_ext = {{32{y_q[31]}}, y_q};
  assign b_ext = {{32{bus_value[31]}}, bus_value};
  assign prod  = y_ext * b_ext;
  // 64-bit division keeps -2^31 / -1 well defined (quotient wraps to 0x80000000)
  assign quo   = (b_ext == 64'sd0) ? 64'sd0 : y_ext / b_ext;
  assign rem   = (b_ext == 64'sd0) ? 64'sd0 : y_ext % b_ext;
  assign amt   = bus_value[4:0];
  assign rot_r = {y_q, y_q} >> amt;
  assign rot_l = {y_q, y_q} << amt;

  always_comb begin
    alu_hi = '0;
    alu_lo = '0;
    case (alu_instruction)
      5'b00000: alu_lo = bus_value;
      5'b00001,
      5'b00011: alu_lo = y_q + bus_value;
      5'b00010: alu_lo = y_q - bus_value;
      5'b00100: alu_lo = y_q & bus_value;
      5'b00101: alu_lo = y_q | bus_value;
      5'b00110: alu_lo = y_q >> amt;
      5'b00111: alu_lo = $signed(y_q) >>> amt;
      5'b01000: alu_lo = y_q << amt;
      5'b01001: alu_lo = rot_r[31:0];
      5'b01010: alu_lo = rot_l[63:32];
      5'b01011: begin
        alu_hi = prod[63:32];
        alu_lo = prod[31:0];
      end
      5'b01100: begin
        alu_hi = rem[31:0];
        alu_lo = quo[31:0];
      end
      5'b01101: alu_lo = -bus_value;
      5'b01110: alu_lo = ~bus_value;
      default: begin
        alu_hi = '0;
        alu_lo = '0;
      end
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    y_d    = y_q;
    z_hi_d = z_hi_q;
    z_lo_d = z_lo_q;
    mar_d  = mar_q;
    mdr_d  = mdr_q;
    if (PC_enable) begin
      pc_d = bus_value;
    end else if (PC_increment_enable) begin
      pc_d = pc_q + 32'd1;
    end
    if (IR_enable)  ir_d  = bus_value;
    if (Y_enable)   y_d   = bus_value;
    if (MAR_enable) mar_d = bus_value;
    if (MDR_enable) mdr_d = mdata_in;
    if (Z_enable) begin
      z_hi_d = alu_hi;
      z_lo_d = alu_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= '0;
      ir_q   <= '0;
      y_q    <= '0;
      z_hi_q <= '0;
      z_lo_q <= '0;
      mar_q  <= '0;
      mdr_q  <= '0;
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= '0;
      end
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      y_q    <= y_d;
      z_hi_q <= z_hi_d;
      z_lo_q <= z_lo_d;
      mar_q  <= mar_d;
      mdr_q  <= mdr_d;
      for (int i = 0; i < 16; i++) begin
        r_q[i] <= r_d[i];
      end
    end
  end

  assign bus_select = bus_code;
  assign bus_Data   = bus_value;
  assign MDataIN    = mdata_in;
  assign R2_Data    = r_q[2];
  assign R3_Data    = r_q[3];
  assign PC_Data    = pc_q;
  assign IR_Data    = ir_q;
  assign Y_Data     = y_q;
  assign Z_HI_Data  = z_hi_q;
  assign Z_LO_Data  = z_lo_q;
  assign MAR_Data   = mar_q;
  assign MDR_Data   = mdr_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: reset, fetch/execute sequences, memory, and ALU vectors/random ops.
module tb_cpu_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        PC_enable, PC_increment_enable, IR_enable, Y_enable, Z_enable;
  logic        MAR_enable, MDR_enable, r_enable, read, write;
  logic        Gra, Grb, ba_select;
  logic        PC_select, Z_LO_select, MDR_select, c_select, r_select;
  logic [4:0]  alu_instruction;
  logic [4:0]  bus_select;
  logic [15:0] register_select;
  logic [31:0] bus_Data, R2_Data, R3_Data, PC_Data, IR_Data, Y_Data;
  logic [31:0] Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data, MDataIN;

  cpu_datapath dut (
    .clk(clk), .reset(reset),
    .PC_enable(PC_enable), .PC_increment_enable(PC_increment_enable),
    .IR_enable(IR_enable), .Y_enable(Y_enable), .Z_enable(Z_enable),
    .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .r_enable(r_enable),
    .read(read), .write(write), .Gra(Gra), .Grb(Grb), .ba_select(ba_select),
    .PC_select(PC_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
    .c_select(c_select), .r_select(r_select), .alu_instruction(alu_instruction),
    .bus_select(bus_select), .register_select(register_select), .bus_Data(bus_Data),
    .R2_Data(R2_Data), .R3_Data(R3_Data), .PC_Data(PC_Data), .IR_Data(IR_Data),
    .Y_Data(Y_Data), .Z_HI_Data(Z_HI_Data), .Z_LO_Data(Z_LO_Data),
    .MAR_Data(MAR_Data), .MDR_Data(MDR_Data), .MDataIN(MDataIN)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, act);
    end
  endtask

  task automatic idle();
    PC_enable = 0; PC_increment_enable = 0; IR_enable = 0; Y_enable = 0;
    Z_enable = 0; MAR_enable = 0; MDR_enable = 0; r_enable = 0;
    read = 0; write = 0; Gra = 0; Grb = 0; ba_select = 0;
    PC_select = 0; Z_LO_select = 0; MDR_select = 0; c_select = 0; r_select = 0;
    alu_instruction = 5'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  // Builds v in Z_LO MSB-first as acc = 2*acc + bit, using R0 == 1 as the constant one
  task automatic build_z(input logic [31:0] v);
    bit started = 0;
    alu_instruction = 5'b00000; Z_enable = 1; cyc();
    for (int i = 31; i >= 0; i--) begin
      if (started) begin
        Z_LO_select = 1; Y_enable = 1; cyc();
        Z_LO_select = 1; alu_instruction = 5'b00001; Z_enable = 1; cyc();
      end
      if (v[i]) begin
        started = 1;
        Z_LO_select = 1; Y_enable = 1; cyc();
        r_select = 1; alu_instruction = 5'b00001; Z_enable = 1; cyc();
      end
    end
  endtask

  task automatic mem_wr(input logic [31:0] addr, input logic [31:0] data);
    build_z(addr); Z_LO_select = 1; MAR_enable = 1; cyc();
    build_z(data); Z_LO_select = 1; MDR_enable = 1; cyc();
    write = 1; cyc();
  endtask

  task automatic alu_run(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] z);
    build_z(a); Z_LO_select = 1; MDR_enable = 1; cyc();
    build_z(b); MDR_select = 1; Y_enable = 1; cyc();
    Z_LO_select = 1; alu_instruction = op; Z_enable = 1; cyc();
    z = {Z_HI_Data, Z_LO_Data};
  endtask

  // Reference ALU from the arithmetic definitions, returns {HI, LO}
  function automatic logic [63:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int unsigned sh;
    logic [31:0] x;
    longint p, q;
    sh = 32'(b[4:0]);
    x = a;
    case (op)
      5'd0:       return {32'd0, b};
      5'd1, 5'd3: return {32'd0, a + b};
      5'd2:       return {32'd0, a - b};
      5'd4:       return {32'd0, a & b};
      5'd5:       return {32'd0, a | b};
      5'd6:       return {32'd0, a >> sh};
      5'd7:       return {32'd0, 32'($signed(a) >>> sh)};
      5'd8:       return {32'd0, a << sh};
      5'd9: begin
        for (int k = 0; k < int'(sh); k++) x = {x[0], x[31:1]};
        return {32'd0, x};
      end
      5'd10: begin
        for (int k = 0; k < int'(sh); k++) x = {x[30:0], x[31]};
        return {32'd0, x};
      end
      5'd11: begin
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
      end
      5'd12: begin
        if (b == 32'd0) return 64'd0;
        p = longint'($signed(a));
        q = longint'($signed(b));
        return {32'(p % q), 32'(p / q)};
      end
      5'd13:      return {32'd0, 32'd0 - b};
      5'd14:      return {32'd0, ~b};
      default:    return 64'd0;
    endcase
  endfunction

  initial begin
    logic [63:0] z;
    logic [4:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{5'b01011, 32'hFFFFFFFA, 32'd4,        64'hFFFFFFFF_FFFFFFE8};
    vecs[1]  = '{5'b01100, 32'd17,       32'd5,        64'h00000002_00000003};
    vecs[2]  = '{5'b01100, 32'd17,       32'd0,        64'h0};
    vecs[3]  = '{5'b00110, 32'h80000000, 32'd4,        64'h08000000};
    vecs[4]  = '{5'b00111, 32'h80000000, 32'd4,        64'hF8000000};
    vecs[5]  = '{5'b01000, 32'd1,        32'd31,       64'h80000000};
    vecs[6]  = '{5'b01001, 32'd1,        32'd1,        64'h80000000};
    vecs[7]  = '{5'b01010, 32'h80000000, 32'd1,        64'h00000001};
    vecs[8]  = '{5'b00010, 32'd5,        32'd7,        64'hFFFFFFFE};
    vecs[9]  = '{5'b00001, 32'hFFFFFFFF, 32'd2,        64'h00000001};
    vecs[10] = '{5'b00100, 32'hF0F0F0F0, 32'h3C3C3C3C, 64'h30303030};
    vecs[11] = '{5'b01101, 32'd9,        32'd1,        64'hFFFFFFFF};
    vecs[12] = '{5'b01110, 32'd9,        32'h0000FFFF, 64'hFFFF0000};
    vecs[13] = '{5'b11111, 32'd9,        32'd9,        64'h0};
    vecs[14] = '{5'b01100, 32'hFFFFFFF9, 32'd2,        64'hFFFFFFFF_FFFFFFFD};
    vecs[15] = '{5'b01000, 32'd1,        32'h21,       64'h00000002};
    vecs[16] = '{5'b00000, 32'd3,        32'h12345678, 64'h12345678};
    vecs[17] = '{5'b01001, 32'h12345678, 32'd0,        64'h12345678};

    idle();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;

    chk("reset R2", {32'd0, R2_Data}, 64'd0);
    chk("reset R3", {32'd0, R3_Data}, 64'd0);
    chk("reset PC", {32'd0, PC_Data}, 64'd0);
    chk("reset IR", {32'd0, IR_Data}, 64'd0);
    chk("reset Y", {32'd0, Y_Data}, 64'd0);
    chk("reset Z", {Z_HI_Data, Z_LO_Data}, 64'd0);
    chk("reset MAR", {32'd0, MAR_Data}, 64'd0);
    chk("reset MDR", {32'd0, MDR_Data}, 64'd0);
    chk("reset bus_select", 64'(bus_select), 64'd31);
    chk("reset bus", {32'd0, bus_Data}, 64'd0);
    chk("reset register_select", 64'(register_select), 64'd0);

    // R0 <- 1: Z = ~0, then Z = -Z, then store through Gra (IR is 0 so Ra = R0)
    alu_instruction = 5'b01110; Z_enable = 1; cyc();
    chk("not 0", {Z_HI_Data, Z_LO_Data}, 64'h00000000_FFFFFFFF);
    Z_LO_select = 1; alu_instruction = 5'b01101; Z_enable = 1; cyc();
    Z_LO_select = 1; Gra = 1; r_enable = 1; cyc();
    r_select = 1; #1;
    chk("R0 on bus", {27'd0, bus_select, bus_Data}, {27'd0, 5'd0, 32'd1});
    idle(); ba_select = 1; #1;
    chk("ba_select R0 drives 0", {32'd0, bus_Data}, 64'd0);
    idle();

    // Memory write / read-back, then simultaneous read+write returns old data
    mem_wr(32'd5, 32'hDEADBEEF);
    read = 1; #1;
    chk("RAM[5] read", {32'd0, MDataIN}, 64'h00000000_DEADBEEF);
    idle();
    build_z(32'h12345678); Z_LO_select = 1; MDR_enable = 1; cyc();
    read = 1; write = 1; MDR_enable = 1; cyc();
    chk("read+write old data", {32'd0, MDR_Data}, 64'h00000000_DEADBEEF);
    read = 1; #1;
    chk("read+write new data", {32'd0, MDataIN}, 64'h00000000_12345678);
    idle();

    mem_wr(32'd0, 32'h01000055);
    mem_wr(32'd1, 32'h018FFFFB);

    // Fetch ldi R2,0x55(R0)
    PC_select = 1; MAR_enable = 1; #1;
    chk("T0 bus_select PC", 64'(bus_select), 64'd18);
    cyc();
    chk("T0 MAR", {32'd0, MAR_Data}, 64'd0);
    read = 1; MDR_enable = 1; PC_increment_enable = 1; cyc();
    chk("T1 MDR", {32'd0, MDR_Data}, 64'h01000055);
    chk("T1 PC", {32'd0, PC_Data}, 64'd1);
    MDR_select = 1; IR_enable = 1; #1;
    chk("T2 bus_select MDR", 64'(bus_select), 64'd19);
    cyc();
    chk("T2 IR", {32'd0, IR_Data}, 64'h01000055);
    Grb = 1; ba_select = 1; Y_enable = 1; cyc();
    chk("T3 Y", {32'd0, Y_Data}, 64'd0);
    c_select = 1; alu_instruction = 5'b00001; Z_enable = 1; #1;
    chk("T4 bus_select C", 64'(bus_select), 64'd20);
    cyc();
    chk("T4 Z", {Z_HI_Data, Z_LO_Data}, 64'h55);
    Z_LO_select = 1; Gra = 1; r_enable = 1; #1;
    chk("T5 register_select", 64'(register_select), 64'h0004);
    chk("T5 bus_select Z_LO", 64'(bus_select), 64'd17);
    cyc();
    chk("T5 R2", {32'd0, R2_Data}, 64'h55);

    // Fetch 0x018FFFFB: Ra=3, Rb=R1 (still 0), C=-5
    PC_select = 1; MAR_enable = 1; cyc();
    read = 1; MDR_enable = 1; PC_increment_enable = 1; cyc();
    MDR_select = 1; IR_enable = 1; cyc();
    chk("addi PC", {32'd0, PC_Data}, 64'd2);
    chk("addi IR", {32'd0, IR_Data}, 64'h018FFFFB);
    c_select = 1; Y_enable = 1; cyc();
    chk("addi Y", {32'd0, Y_Data}, 64'hFFFFFFFB);
    Grb = 1; r_select = 1; alu_instruction = 5'b00011; Z_enable = 1; #1;
    chk("addi bus_select Rb", 64'(bus_select), 64'd1);
    cyc();
    chk("addi Z", {Z_HI_Data, Z_LO_Data}, 64'h00000000_FFFFFFFB);
    Z_LO_select = 1; Gra = 1; r_enable = 1; cyc();
    chk("addi R3", {32'd0, R3_Data}, 64'hFFFFFFFB);
    chk("addi R2 kept", {32'd0, R2_Data}, 64'h55);

    // PC_enable beats PC_increment_enable
    build_z(32'd7);
    Z_LO_select = 1; PC_enable = 1; PC_increment_enable = 1; cyc();
    chk("PC load priority", {32'd0, PC_Data}, 64'd7);
    PC_increment_enable = 1; cyc();
    chk("PC increment", {32'd0, PC_Data}, 64'd8);

    for (int i = 0; i < NVEC; i++) begin
      alu_run(vecs[i].op, vecs[i].a, vecs[i].b, z);
      chk($sformatf("vec%0d op=%b a=%h b=%h", i, vecs[i].op, vecs[i].a, vecs[i].b), z, vecs[i].z);
    end

    for (int i = 0; i < 30; i++) begin
      op = 5'($urandom_range(0, 17));
      a = $urandom();
      b = $urandom();
      if (op == 5'b01100 && i[0]) b = 32'($urandom_range(1, 100));
      alu_run(op, a, b, z);
      chk($sformatf("rand%0d op=%b a=%h b=%h", i, op, a, b), z, alu_model(op, a, b));
    end

    // Reset clears registers but leaves RAM alone
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("reset2 PC", {32'd0, PC_Data}, 64'd0);
    chk("reset2 R3", {32'd0, R3_Data}, 64'd0);
    chk("reset2 Z", {Z_HI_Data, Z_LO_Data}, 64'd0);
    read = 1; #1;
    chk("reset2 RAM[0] kept", {32'd0, MDataIN}, 64'h01000055);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
